// File: rtl/msg_stream_pkg.sv
// Shared definitions for the message-stream combiner: header-word helpers,
// FSM state encoding and arbitration-mode constants.
package msg_stream_pkg;

   // Widest word the header helpers accept.
   localparam int unsigned MAX_WORD = 64;

   // FSM state encoding.
   typedef logic [0:0] fsm_state_t;
   localparam fsm_state_t ST_IDLE   = 1'b0;
   localparam fsm_state_t ST_PACKET = 1'b1;

   // Arbitration modes.
   localparam int unsigned ARB_RR    = 0;
   localparam int unsigned ARB_FIXED = 1;

   // Position of the header flag in a word of the given width.
   function automatic int unsigned hdr_bit(input int unsigned width);
      return width - 1;
   endfunction

   // True when the word carries the header flag.
   function automatic logic is_header(input logic [MAX_WORD-1:0] w,
                                      input int unsigned width);
      return 1'(w >> hdr_bit(width));
   endfunction

   // Payload length L, taken from the field just below the header flag.
   function automatic int unsigned hdr_len(input logic [MAX_WORD-1:0] w,
                                           input int unsigned width,
                                           input int unsigned len_w);
      logic [MAX_WORD-1:0] mask;
      mask = (MAX_WORD'(1) << len_w) - MAX_WORD'(1);
      return 32'((w >> (hdr_bit(width) - len_w)) & mask);
   endfunction

endpackage

// File: rtl/msg_stream_arbiter_if.sv
// Bus bundle of the message-stream combiner.
//   slave  : combiner side (takes input streams and out_ready, drives the rest)
//   master : producer/sink side
interface msg_stream_arbiter_if #(
   parameter int unsigned N_STREAMS     = 4,
   parameter int unsigned LOG_N_STREAMS = 2,
   parameter int unsigned WIDTH         = 32
);
   logic [WIDTH*N_STREAMS-1:0] in_data;
   logic [N_STREAMS-1:0]       in_nd;
   logic [N_STREAMS-1:0]       in_afull;
   logic [WIDTH-1:0]           out_data;
   logic                       out_nd;
   logic [LOG_N_STREAMS-1:0]   out_stream;
   logic                       out_ready;
   logic [N_STREAMS-1:0]       overflow;
   logic [N_STREAMS-1:0]       framing_error;
   logic                       error;

   modport master (
      output in_data, in_nd, out_ready,
      input  in_afull, out_data, out_nd, out_stream, overflow, framing_error, error
   );

   modport slave (
      input  in_data, in_nd, out_ready,
      output in_afull, out_data, out_nd, out_stream, overflow, framing_error, error
   );
endinterface

// File: rtl/msa_fifo.sv
// Show-ahead FIFO with fill count.
//   push/push_data : write strobe and word; accepted when not full or when
//                    popping in the same cycle
//   pop            : consume head (ignored when empty)
//   head           : oldest word, valid while !empty
//   empty/full     : status derived from the count register
//   count          : words held
module msa_fifo #(
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned FIFO_DEPTH     = 64,
   parameter int unsigned LOG_FIFO_DEPTH = 6
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push,
   input  logic [WIDTH-1:0]        push_data,
   input  logic                    pop,
   output logic [WIDTH-1:0]        head,
   output logic                    empty,
   output logic                    full,
   output logic [LOG_FIFO_DEPTH:0] count
);
   localparam int unsigned CW = LOG_FIFO_DEPTH + 1;

   logic [WIDTH-1:0]          mem [FIFO_DEPTH];
   logic [LOG_FIFO_DEPTH-1:0] wr_ptr;
   logic [LOG_FIFO_DEPTH-1:0] rd_ptr;
   logic                      push_ok;
   logic                      pop_ok;

   assign empty   = (count == '0);
   assign full    = (count == CW'(FIFO_DEPTH));
   // A full FIFO still takes a word when the head leaves in the same cycle.
   assign push_ok = push && (!full || pop);
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Storage, not reset.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   // Pointers and count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + LOG_FIFO_DEPTH'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + LOG_FIFO_DEPTH'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/msg_stream_arbiter.sv
// N-input message-stream combiner. Each input is buffered in a msa_fifo;
// whole packets (header + L payload words) are forwarded atomically onto one
// output stream, the next source chosen at each packet boundary by a
// round-robin or fixed-priority arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of msg_stream_arbiter_if (input streams, output
//                stream with out_ready backpressure, almost-full and sticky
//                overflow / framing flags)
module msg_stream_arbiter
   import msg_stream_pkg::*;
#(
   parameter int unsigned N_STREAMS             = 4,
   parameter int unsigned LOG_N_STREAMS         = 2,
   parameter int unsigned WIDTH                 = 32,
   parameter int unsigned FIFO_DEPTH            = 64,
   parameter int unsigned LOG_FIFO_DEPTH        = 6,
   parameter int unsigned LOG_MAX_PACKET_LENGTH = 10,
   parameter int unsigned AFULL_LEVEL           = 56,
   parameter int unsigned ARB_MODE              = 0
) (
   input logic                clk,
   input logic                rst_n,
   msg_stream_arbiter_if.slave bus
);
   localparam int unsigned LW = LOG_MAX_PACKET_LENGTH;
   localparam int unsigned SW = LOG_N_STREAMS;

   logic [N_STREAMS-1:0]    nonempty;
   logic [N_STREAMS-1:0]    full_v;
   logic [N_STREAMS-1:0]    pop;
   logic [N_STREAMS-1:0]    drop;
   logic [N_STREAMS-1:0]    fe_set;
   logic [WIDTH-1:0]        head  [N_STREAMS];
   logic [LOG_FIFO_DEPTH:0] count [N_STREAMS];

   fsm_state_t     state, state_n;
   logic [LW-1:0]  remaining, remaining_n;
   logic [SW-1:0]  cur, cur_n;
   logic [SW-1:0]  last_grant, last_grant_n;
   logic [WIDTH-1:0] out_data_q, out_data_n;
   logic           out_nd_q, out_nd_n;
   logic [SW-1:0]  out_stream_q, out_stream_n;
   logic [N_STREAMS-1:0] afull_q, overflow_q, fe_q;
   logic           error_q;

   logic           adv;
   logic [SW-1:0]  pick;
   logic [WIDTH-1:0] pick_head;
   logic [LW-1:0]  pick_len;

   // Per-stream input buffers.
   for (genvar i = 0; i < N_STREAMS; i++) begin : g_fifo
      logic empty_i;
      msa_fifo #(
         .WIDTH         (WIDTH),
         .FIFO_DEPTH    (FIFO_DEPTH),
         .LOG_FIFO_DEPTH(LOG_FIFO_DEPTH)
      ) u_fifo (
         .clk      (clk),
         .rst_n    (rst_n),
         .push     (bus.in_nd[i]),
         .push_data(bus.in_data[WIDTH*(i+1)-1 -: WIDTH]),
         .pop      (pop[i]),
         .head     (head[i]),
         .empty    (empty_i),
         .full     (full_v[i]),
         .count    (count[i])
      );
      assign nonempty[i] = !empty_i;
      assign drop[i]     = bus.in_nd[i] && full_v[i] && !pop[i];
   end

   // Grant selection: round-robin from last_grant+1, or lowest index first.
   function automatic logic [SW-1:0] arb_pick(input logic [N_STREAMS-1:0] req,
                                              input logic [SW-1:0] last);
      logic        found;
      int unsigned idx;
      arb_pick = '0;
      found    = 1'b0;
      for (int unsigned k = 0; k < N_STREAMS; k++) begin
         if (ARB_MODE == ARB_RR) idx = (32'(last) + 32'd1 + k) % N_STREAMS;
         else                    idx = k;
         if (!found && req[idx[SW-1:0]]) begin
            arb_pick = SW'(idx);
            found    = 1'b1;
         end
      end
   endfunction

   // Output register moves whenever it is empty or being accepted.
   assign adv       = !out_nd_q || bus.out_ready;
   assign pick      = arb_pick(nonempty, last_grant);
   assign pick_head = head[pick];
   assign pick_len  = LW'(hdr_len(MAX_WORD'(pick_head), WIDTH, LW));

   // Packet framing FSM and output next-state.
   always_comb begin
      state_n      = state;
      remaining_n  = remaining;
      cur_n        = cur;
      last_grant_n = last_grant;
      out_data_n   = out_data_q;
      out_nd_n     = out_nd_q;
      out_stream_n = out_stream_q;
      pop          = '0;
      fe_set       = '0;
      if (adv) begin
         case (state)
            ST_IDLE: begin
               if (|nonempty) begin
                  pop[pick] = 1'b1;
                  if (is_header(MAX_WORD'(pick_head), WIDTH)) begin
                     out_data_n   = pick_head;
                     out_nd_n     = 1'b1;
                     out_stream_n = pick;
                     last_grant_n = pick;
                     if (pick_len != '0) begin
                        remaining_n = pick_len;
                        cur_n       = pick;
                        state_n     = ST_PACKET;
                     end
                  end else begin
                     // Stray payload at a boundary is dropped, costing one cycle.
                     fe_set[pick] = 1'b1;
                     out_nd_n     = 1'b0;
                  end
               end else begin
                  out_nd_n = 1'b0;
               end
            end
            default: begin
               // Locked to cur until the packet completes; no interleaving.
               if (nonempty[cur]) begin
                  pop[cur]     = 1'b1;
                  out_data_n   = head[cur];
                  out_nd_n     = 1'b1;
                  out_stream_n = cur;
                  remaining_n  = remaining - LW'(1);
                  if (remaining == LW'(1)) state_n = ST_IDLE;
               end else begin
                  out_nd_n = 1'b0;
               end
            end
         endcase
      end
   end

   // FSM and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         remaining    <= '0;
         cur          <= '0;
         last_grant   <= SW'(N_STREAMS - 1);
         out_data_q   <= '0;
         out_nd_q     <= 1'b0;
         out_stream_q <= '0;
      end else begin
         state        <= state_n;
         remaining    <= remaining_n;
         cur          <= cur_n;
         last_grant   <= last_grant_n;
         out_data_q   <= out_data_n;
         out_nd_q     <= out_nd_n;
         out_stream_q <= out_stream_n;
      end
   end

   // Status flags; error follows the flags in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         afull_q    <= '0;
         overflow_q <= '0;
         fe_q       <= '0;
         error_q    <= 1'b0;
      end else begin
         overflow_q <= overflow_q | drop;
         fe_q       <= fe_q | fe_set;
         error_q    <= |{overflow_q, drop, fe_q, fe_set};
         for (int unsigned i = 0; i < N_STREAMS; i++) begin
            afull_q[i] <= (32'(count[i]) >= AFULL_LEVEL);
         end
      end
   end

   assign bus.out_data      = out_data_q;
   assign bus.out_nd        = out_nd_q;
   assign bus.out_stream    = out_stream_q;
   assign bus.in_afull      = afull_q;
   assign bus.overflow      = overflow_q;
   assign bus.framing_error = fe_q;
   assign bus.error         = error_q;
endmodule

// File: tb/tb_msg_stream_arbiter.sv
// Directed bench for msg_stream_arbiter: one round-robin instance and one
// fixed-priority instance, inputs driven 1 ns after each rising edge and
// outputs sampled at the same point.
module tb_msg_stream_arbiter;
   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   msg_stream_arbiter_if bus_rr ();
   msg_stream_arbiter_if bus_fp ();

   msg_stream_arbiter #(.ARB_MODE(0)) u_rr (.clk(clk), .rst_n(rst_n), .bus(bus_rr));
   msg_stream_arbiter #(.ARB_MODE(1)) u_fp (.clk(clk), .rst_n(rst_n), .bus(bus_fp));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] hdr(input int unsigned l, input logic [31:0] low);
      return 32'h8000_0000 | 32'(l << 21) | low;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic beat(input string tag, input bit fp, input logic [31:0] d, input logic [31:0] s);
      if (fp) begin
         chk({tag, ".nd"}, 32'(bus_fp.out_nd), 1);
         chk({tag, ".data"}, bus_fp.out_data, d);
         chk({tag, ".stream"}, 32'(bus_fp.out_stream), s);
      end else begin
         chk({tag, ".nd"}, 32'(bus_rr.out_nd), 1);
         chk({tag, ".data"}, bus_rr.out_data, d);
         chk({tag, ".stream"}, 32'(bus_rr.out_stream), s);
      end
   endtask

   task automatic idle(input string tag, input bit fp);
      if (fp) chk({tag, ".nd"}, 32'(bus_fp.out_nd), 0);
      else    chk({tag, ".nd"}, 32'(bus_rr.out_nd), 0);
   endtask

   task automatic put_rr(input logic [1:0] i, input logic [31:0] w);
      bus_rr.in_data[32*i +: 32] = w;
      bus_rr.in_nd[i] = 1'b1;
   endtask

   task automatic put_fp(input logic [1:0] i, input logic [31:0] w);
      bus_fp.in_data[32*i +: 32] = w;
      bus_fp.in_nd[i] = 1'b1;
   endtask

   task automatic clr();
      bus_rr.in_nd = '0;
      bus_fp.in_nd = '0;
   endtask

   task automatic all_zero(input string tag);
      chk({tag, ".out_nd"}, 32'(bus_rr.out_nd), 0);
      chk({tag, ".out_data"}, bus_rr.out_data, 0);
      chk({tag, ".out_stream"}, 32'(bus_rr.out_stream), 0);
      chk({tag, ".in_afull"}, 32'(bus_rr.in_afull), 0);
      chk({tag, ".overflow"}, 32'(bus_rr.overflow), 0);
      chk({tag, ".framing"}, 32'(bus_rr.framing_error), 0);
      chk({tag, ".error"}, 32'(bus_rr.error), 0);
   endtask

   task automatic do_reset();
      clr();
      bus_rr.out_ready = 1'b0;
      bus_fp.out_ready = 1'b0;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      bus_rr.in_data = '0;
      bus_rr.in_nd = '0;
      bus_rr.out_ready = 1'b0;
      bus_fp.in_data = '0;
      bus_fp.in_nd = '0;
      bus_fp.out_ready = 1'b0;
      #12;
      all_zero("reset");
      idle("reset.fp", 1'b1);
      rst_n = 1'b1;
      tick();

      // Single stream: header L=3 then A,B,C; first beat 2 cycles after header.
      bus_rr.out_ready = 1'b1;
      put_rr(0, hdr(3, 0));
      tick();
      put_rr(0, 32'hA);
      idle("t1.latency", 1'b0);
      tick();
      beat("t1.hdr", 1'b0, 32'h8060_0000, 0);
      put_rr(0, 32'hB);
      tick();
      beat("t1.a", 1'b0, 32'hA, 0);
      put_rr(0, 32'hC);
      tick();
      beat("t1.b", 1'b0, 32'hB, 0);
      clr();
      tick();
      beat("t1.c", 1'b0, 32'hC, 0);
      tick();
      idle("t1.end", 1'b0);

      // Round-robin over two header-only words per stream, no gaps.
      do_reset();
      bus_rr.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) put_rr(2'(i), hdr(0, 32'(i * 16)));
      tick();
      for (int i = 0; i < 4; i++) put_rr(2'(i), hdr(0, 32'(i * 16 + 1)));
      tick();
      clr();
      for (int k = 0; k < 8; k++) begin
         beat("t2.rr", 1'b0, hdr(0, 32'((k % 4) * 16 + k / 4)), 32'(k % 4));
         tick();
      end
      idle("t2.end", 1'b0);

      // Fixed priority: stream 1 packet completes before newly loaded stream 0, then 3.
      do_reset();
      bus_fp.out_ready = 1'b1;
      put_fp(1, hdr(2, 32'h11));
      put_fp(3, hdr(1, 32'h33));
      tick();
      put_fp(1, 32'h111);
      put_fp(3, 32'h333);
      idle("t3.latency", 1'b1);
      tick();
      beat("t3.s1hdr", 1'b1, 32'h8040_0011, 1);
      clr();
      put_fp(1, 32'h112);
      put_fp(0, hdr(0, 32'h01));
      tick();
      beat("t3.s1p0", 1'b1, 32'h111, 1);
      clr();
      tick();
      beat("t3.s1p1", 1'b1, 32'h112, 1);
      tick();
      beat("t3.s0hdr", 1'b1, 32'h8000_0001, 0);
      tick();
      beat("t3.s3hdr", 1'b1, 32'h8020_0033, 3);
      tick();
      beat("t3.s3p0", 1'b1, 32'h333, 3);
      tick();
      idle("t3.end", 1'b1);

      // Backpressure: out_ready low for 5 edges mid-packet.
      do_reset();
      bus_rr.out_ready = 1'b1;
      put_rr(2, hdr(4, 32'h2));
      tick();
      put_rr(2, 32'h21);
      tick();
      beat("t4.hdr", 1'b0, 32'h8080_0002, 2);
      put_rr(2, 32'h22);
      tick();
      beat("t4.p0", 1'b0, 32'h21, 2);
      put_rr(2, 32'h23);
      bus_rr.out_ready = 1'b0;
      tick();
      beat("t4.hold", 1'b0, 32'h21, 2);
      put_rr(2, 32'h24);
      tick();
      beat("t4.hold", 1'b0, 32'h21, 2);
      clr();
      for (int k = 0; k < 3; k++) begin
         tick();
         beat("t4.hold", 1'b0, 32'h21, 2);
      end
      bus_rr.out_ready = 1'b1;
      tick();
      beat("t4.p1", 1'b0, 32'h22, 2);
      tick();
      beat("t4.p2", 1'b0, 32'h23, 2);
      tick();
      beat("t4.p3", 1'b0, 32'h24, 2);
      tick();
      idle("t4.end", 1'b0);

      // Overflow: output stalled on a stream-0 word, 65 writes to stream 2.
      do_reset();
      put_rr(0, hdr(0, 32'h5));
      tick();
      clr();
      tick();
      beat("t5.stall", 1'b0, 32'h8000_0005, 0);
      for (int k = 1; k <= 65; k++) begin
         put_rr(2, hdr(0, 32'(k)));
         tick();
         if (k == 56) chk("t5.afull_before", 32'(bus_rr.in_afull), 0);
         if (k == 57) chk("t5.afull_rise", 32'(bus_rr.in_afull), 32'h4);
         if (k == 64) chk("t5.ovf_before", 32'(bus_rr.overflow), 0);
      end
      clr();
      tick();
      chk("t5.overflow", 32'(bus_rr.overflow), 32'h4);
      chk("t5.error", 32'(bus_rr.error), 1);
      chk("t5.afull", 32'(bus_rr.in_afull), 32'h4);
      beat("t5.still", 1'b0, 32'h8000_0005, 0);
      bus_rr.out_ready = 1'b1;
      for (int k = 1; k <= 64; k++) begin
         tick();
         beat("t5.drain", 1'b0, hdr(0, 32'(k)), 2);
      end
      tick();
      idle("t5.dropped", 1'b0);

      // Framing error on stream 1, then asynchronous reset mid-packet.
      do_reset();
      bus_rr.out_ready = 1'b1;
      put_rr(1, 32'h0000_0005);
      tick();
      put_rr(1, hdr(1, 32'h1));
      chk("t6.fe_before", 32'(bus_rr.framing_error), 0);
      tick();
      put_rr(1, 32'h77);
      idle("t6.discard", 1'b0);
      tick();
      beat("t6.hdr", 1'b0, 32'h8020_0001, 1);
      chk("t6.framing", 32'(bus_rr.framing_error), 32'h2);
      chk("t6.error", 32'(bus_rr.error), 1);
      put_rr(1, hdr(3, 32'h9));
      tick();
      beat("t6.p0", 1'b0, 32'h77, 1);
      put_rr(1, 32'h91);
      tick();
      beat("t6.hdr2", 1'b0, 32'h8060_0009, 1);
      clr();
      tick();
      beat("t6.mid", 1'b0, 32'h91, 1);
      #1;
      rst_n = 1'b0;
      #1;
      all_zero("t6.async_reset");
      #2;
      rst_n = 1'b1;
      tick();
      tick();
      idle("t6.after_reset", 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
